// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// cdb_arbiter_if : result-source and CDB broadcast signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface cdb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 3
);
  logic              add_valid;
  logic [TAG_W-1:0]  add_tag;
  logic [DATA_W-1:0] add_data;
  logic              add_ready;

  logic              mul_valid;
  logic [TAG_W-1:0]  mul_tag;
  logic [DATA_W-1:0] mul_data;
  logic              mul_ready;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_src;

  // Functional units and CDB consumers
  modport master (
    output add_valid, add_tag, add_data,
    output mul_valid, mul_tag, mul_data,
    input  add_ready, mul_ready,
    input  cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  // Arbiter side
  modport slave (
    input  add_valid, add_tag, add_data,
    input  mul_valid, mul_tag, mul_data,
    output add_ready, mul_ready,
    output cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// cdb_arbiter : round-robin CDB arbiter between ADD and MUL result FIFOs
// Optional perf counters enabled with macro CDB_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module cdb_arbiter #(
  parameter int DATA_W     = 8,
  parameter int TAG_W      = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  cdb_arbiter_if.slave  bus
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [15:0]   add_bcast_cnt,
  output logic [15:0]   mul_bcast_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic SRC_ADD = 1'b0;
  localparam logic SRC_MUL = 1'b1;

  // Source index 0 = ADD, 1 = MUL throughout
  logic [1:0]        in_valid;
  logic [TAG_W-1:0]  in_tag  [2];
  logic [DATA_W-1:0] in_data [2];

  logic [TAG_W-1:0]  tag_mem  [2][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr   [2];
  logic [PTR_W-1:0]  rd_ptr   [2];
  logic [CNT_W-1:0]  count    [2];

  logic [1:0] full;
  logic [1:0] not_empty;
  logic [1:0] push;
  logic [1:0] pop;

  logic grant_valid;
  logic grant_src;
  logic last_grant;

  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic              out_src;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    in_valid   = {bus.mul_valid, bus.add_valid};
    in_tag[0]  = bus.add_tag;
    in_tag[1]  = bus.mul_tag;
    in_data[0] = bus.add_data;
    in_data[1] = bus.mul_data;
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      full[s]      = (count[s] == CNT_W'(FIFO_DEPTH));
      not_empty[s] = (count[s] != '0);
    end
  end

  // Full blocks a push even when the same FIFO pops this cycle
  assign push = in_valid & ~full;

  // Arbitration looks only at occupancy at the start of the cycle
  always_comb begin
    grant_valid = |not_empty;
    grant_src   = SRC_ADD;
    if (&not_empty) begin
      grant_src = ~last_grant;
    end else if (not_empty[1]) begin
      grant_src = SRC_MUL;
    end
    pop[0] = grant_valid && (grant_src == SRC_ADD);
    pop[1] = grant_valid && (grant_src == SRC_MUL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          tag_mem[s][i]  <= '0;
          data_mem[s][i] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          tag_mem[s][wr_ptr[s]]  <= in_tag[s];
          data_mem[s][wr_ptr[s]] <= in_data[s];
          wr_ptr[s]              <= next_ptr(wr_ptr[s]);
        end
        if (pop[s]) begin
          rd_ptr[s] <= next_ptr(rd_ptr[s]);
        end
        count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
    end
  end

  // Broadcast register: tag/data/src hold their last value on idle cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_tag    <= '0;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= SRC_MUL;
    end else begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_tag    <= tag_mem[grant_src][rd_ptr[grant_src]];
        out_data   <= data_mem[grant_src][rd_ptr[grant_src]];
        out_src    <= grant_src;
        last_grant <= grant_src;
      end
    end
  end

  assign bus.add_ready = ~full[0];
  assign bus.mul_ready = ~full[1];
  assign bus.cdb_valid = out_valid;
  assign bus.cdb_tag   = out_tag;
  assign bus.cdb_data  = out_data;
  assign bus.cdb_src   = out_src;

`ifdef CDB_PERF_CNT_EN
  logic stall;
  assign stall = |(in_valid & full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_bcast_cnt <= '0;
      mul_bcast_cnt <= '0;
      stall_cnt     <= '0;
    end else begin
      if (pop[0] && (add_bcast_cnt != 16'hFFFF)) begin
        add_bcast_cnt <= add_bcast_cnt + 16'd1;
      end
      if (pop[1] && (mul_bcast_cnt != 16'hFFFF)) begin
        mul_bcast_cnt <= mul_bcast_cnt + 16'd1;
      end
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// tb_cdb_arbiter : directed self-checking bench for cdb_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

  localparam int DATA_W     = 8;
  localparam int TAG_W      = 3;
  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

`ifdef CDB_PERF_CNT_EN
  logic [15:0] add_bcast_cnt;
  logic [15:0] mul_bcast_cnt;
  logic [15:0] stall_cnt;
`endif

  cdb_arbiter #(
    .DATA_W     (DATA_W),
    .TAG_W      (TAG_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CDB_PERF_CNT_EN
    ,
    .add_bcast_cnt (add_bcast_cnt),
    .mul_bcast_cnt (mul_bcast_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.add_valid = 1'b0;
    bus.add_tag   = '0;
    bus.add_data  = '0;
    bus.mul_valid = 1'b0;
    bus.mul_tag   = '0;
    bus.mul_data  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Streams na ADD and nm MUL results, each source advancing only on acceptance.
  // Expected broadcast order: strict ADD/MUL alternation starting with ADD.
  task automatic run_stream(input int na, input int nm, input bit bp, input string name);
    logic [TAG_W-1:0]  etag[$];
    logic [DATA_W-1:0] edata[$];
    logic              esrc[$];
    int ai = 0, mi = 0, bi = 0, first = -1, last = -1;
    int a = 0, m = 0;
    bit turn = 1'b0;
    bit acc_a, acc_m;
    int ai_v, mi_v;
    while (a < na || m < nm) begin
      if ((!turn && a < na) || m >= nm) begin
        ai_v = a;
        etag.push_back(ai_v[TAG_W-1:0]);
        edata.push_back(8'h10 + ai_v[7:0]);
        esrc.push_back(1'b0);
        a++;
        turn = 1'b1;
      end else begin
        mi_v = m;
        etag.push_back(3'd7 - mi_v[TAG_W-1:0]);
        edata.push_back(8'h80 + mi_v[7:0]);
        esrc.push_back(1'b1);
        m++;
        turn = 1'b0;
      end
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.add_valid = (ai < na);
      bus.add_tag   = ai[TAG_W-1:0];
      bus.add_data  = 8'h10 + ai[7:0];
      bus.mul_valid = (mi < nm);
      bus.mul_tag   = 3'd7 - mi[TAG_W-1:0];
      bus.mul_data  = 8'h80 + mi[7:0];
      acc_a = bus.add_valid && bus.add_ready;
      acc_m = bus.mul_valid && bus.mul_ready;
      step();
      ai += int'(acc_a);
      mi += int'(acc_m);
      if (bp && cyc == 1) check({name, " mul_ready_full"}, bus.mul_ready, 0);
      if (bp && cyc == 2) check({name, " mul_ready_after_pop"}, bus.mul_ready, 1);
      if (bus.cdb_valid) begin
        if (bi < etag.size()) begin
          check({name, " tag"}, bus.cdb_tag, etag[bi]);
          check({name, " data"}, bus.cdb_data, edata[bi]);
          check({name, " src"}, bus.cdb_src, esrc[bi]);
        end else begin
          check({name, " extra_bcast"}, 1, 0);
        end
        if (first < 0) first = cyc + 1;
        last = cyc + 1;
        bi++;
      end
    end
    idle_inputs();
    check({name, " bcast_count"}, bi, na + nm);
    check({name, " first_edge"}, first, 2);
    check({name, " last_edge"}, last, na + nm + 1);
  endtask

  initial begin
    idle_inputs();

    // Reset state and idle behaviour
    apply_reset();
    check("rst cdb_valid", bus.cdb_valid, 0);
    check("rst cdb_tag", bus.cdb_tag, 0);
    check("rst cdb_data", bus.cdb_data, 0);
    check("rst cdb_src", bus.cdb_src, 0);
    check("rst add_ready", bus.add_ready, 1);
    check("rst mul_ready", bus.mul_ready, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle cdb_valid", bus.cdb_valid, 0);
    end

    // Single ADD result
    apply_reset();
    bus.add_valid = 1'b1;
    bus.add_tag   = 3'd1;
    bus.add_data  = 8'h03;
    step();
    idle_inputs();
    check("single k valid", bus.cdb_valid, 0);
    step();
    check("single valid", bus.cdb_valid, 1);
    check("single tag", bus.cdb_tag, 1);
    check("single data", bus.cdb_data, 8'h03);
    check("single src", bus.cdb_src, 0);
    step();
    check("single k2 valid", bus.cdb_valid, 0);
    check("single hold tag", bus.cdb_tag, 1);

    // Simultaneous push: ADD wins the first tie
    apply_reset();
    bus.add_valid = 1'b1;
    bus.add_tag   = 3'd1;
    bus.add_data  = 8'h03;
    bus.mul_valid = 1'b1;
    bus.mul_tag   = 3'd5;
    bus.mul_data  = 8'h14;
    step();
    idle_inputs();
    step();
    check("simul1 valid", bus.cdb_valid, 1);
    check("simul1 src", bus.cdb_src, 0);
    check("simul1 tag", bus.cdb_tag, 1);
    check("simul1 data", bus.cdb_data, 8'h03);
    step();
    check("simul2 valid", bus.cdb_valid, 1);
    check("simul2 src", bus.cdb_src, 1);
    check("simul2 tag", bus.cdb_tag, 5);
    check("simul2 data", bus.cdb_data, 8'h14);
    step();
    check("simul3 valid", bus.cdb_valid, 0);

    // Back-pressure on MUL while ADD stays busy
    apply_reset();
    run_stream(4, 3, 1'b1, "bp");

    // Continuous contention fairness
    apply_reset();
    run_stream(8, 8, 1'b0, "fair");

    // Reset mid-operation with FIFOs loaded
    apply_reset();
    bus.add_valid = 1'b1;
    bus.mul_valid = 1'b1;
    bus.add_tag   = 3'd2;
    bus.mul_tag   = 3'd6;
    bus.add_data  = 8'h22;
    bus.mul_data  = 8'h66;
    repeat (3) step();
    check("mid pre valid", bus.cdb_valid, 1);
    check("mid pre add_ready", bus.add_ready, 0);
    rst = 1'b1;
    #1;
    check("mid rst valid", bus.cdb_valid, 0);
    check("mid rst add_ready", bus.add_ready, 1);
    check("mid rst mul_ready", bus.mul_ready, 1);
`ifdef CDB_PERF_CNT_EN
    check("mid rst add_cnt", add_bcast_cnt, 0);
    check("mid rst mul_cnt", mul_bcast_cnt, 0);
    check("mid rst stall_cnt", stall_cnt, 0);
`endif
    idle_inputs();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid post valid", bus.cdb_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
